regfile_dump_reader: RTL

- Debug readout engine for the CPU register bank. It is the reader counterpart to the register file's write side.
- On a start pulse it walks every register address from 0 to 2**Addr_B-1 through a dedicated combinational debug read port.
- Each 32-bit word is captured, then streamed MSB-byte-first over a valid/ready byte interface feeding the debug UART transmitter.
- It sits beside the register file in the top level and never touches the pipeline's two read ports or its write port.

---
 rtl/regfile_dump_reader_pkg.sv | 26 ++
 rtl/regfile_dump_reader_word_byte_serializer.sv | 60 ++++++
 rtl/regfile_dump_reader.sv | 93 +++++++++
 3 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// rtl/regfile_dump_reader_pkg.sv - shared constants and state encoding for the register dump reader
package regfile_dump_reader_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_WIDTH_B    = 32;
    localparam int DEF_ADDR_B     = 5;
    localparam int BYTES_PER_WORD = DEF_WIDTH_B / BYTE_W;
    localparam int NUM_REGS       = 2 ** DEF_ADDR_B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int bytes_per_word(input int width);
        return width / BYTE_W;
    endfunction

    // Keeps counters at least one bit wide when a word is a single byte.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_word_byte_serializer.sv
// rtl/regfile_dump_reader_word_byte_serializer.sv - loads a word and emits it MSB byte first over valid/ready
module word_byte_serializer
    import regfile_dump_reader_pkg::*;
#(
    parameter int width_B = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [width_B-1:0] word_i,
    input  logic               ready_i,
    output logic [BYTE_W-1:0]  data_o,
    output logic               valid_o,
    output logic               last_byte_o,
    output logic               fire_o
);

    localparam int BPW   = bytes_per_word(width_B);
    localparam int CNT_W = cnt_width(BPW);

    logic [width_B-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;

    assign fire_o      = valid_q & ready_i;
    assign last_byte_o = (cnt_q == CNT_W'(BPW - 1));
    assign data_o      = shift_q[width_B-1 -: BYTE_W];
    assign valid_o     = valid_q;

    // Valid stays up across stalls and only falls after the last byte is taken.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = word_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (fire_o) begin
            shift_d = shift_q << BYTE_W;
            cnt_d   = cnt_q + 1'b1;
            if (last_byte_o) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks the register file debug port and streams every word as bytes
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int width_B = 32,
    parameter int Addr_B  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [Addr_B-1:0]  Dbg_Addr,
    input  logic [width_B-1:0] Dbg_Data,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               done
);

    localparam logic [Addr_B-1:0] ADDR_MAX = '1;

    state_t            state_q, state_d;
    logic [Addr_B-1:0] addr_q, addr_d;
    logic              load;
    logic              fire;
    logic              last_byte;

    assign Dbg_Addr = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // End of dump is the all-ones address, so the counter never wraps into a second pass.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ADDR;
                    addr_d  = '0;
                end
            end
            ST_ADDR: state_d = ST_SEND;
            ST_SEND: begin
                if (fire && last_byte) begin
                    if (addr_q == ADDR_MAX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADDR;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_comb begin
        load = (state_q == ST_ADDR);
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    word_byte_serializer #(
        .width_B (width_B)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .word_i      (Dbg_Data),
        .ready_i     (tx_ready),
        .data_o      (tx_data),
        .valid_o     (tx_valid),
        .last_byte_o (last_byte),
        .fire_o      (fire)
    );

endmodule
